// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multiport register file.
//   state_t  : clear-sequencer states (CLEAR, IDLE)
//   be_merge : byte-enable merge of a new word into an old word
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Widest entry the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW = 256;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0]   old_v,
        input logic [MAX_DW-1:0]   new_v,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] m;
        m = old_v;
        for (int k = 0; k < MAX_DW/8; k++) begin
            if (be[k]) m[8*k +: 8] = new_v[8*k +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: walks every entry writing zero, then idles until clr_req.
//   clk      : clock
//   arst_n   : asynchronous active-low reset (restarts the clear)
//   clr_req  : start a clear sequence (honoured only in IDLE)
//   busy     : high while the clear runs
//   clr_we   : write-zero strobe to storage
//   clr_addr : entry being zeroed
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt,   w_cnt_nxt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                busy      = 1'b1;
                clr_we    = 1'b1;
                // Counter wraps to 0 on the last entry, so IDLE starts at 0.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_addr = r_cnt;

endmodule

// File: rtl/multiport_reg_file.sv
// Multiport register file: one byte-enabled write port, NUM_RD combinational
// read ports, optional hardwired-zero entry 0, optional write->read bypass,
// and a sequenced clear (run after reset and on clr_req).
//   clk, arst_n            : clock, asynchronous active-low reset
//   we, w_addr, w_data, w_be : write request with byte enables
//   clr_req                : request to zero every entry
//   r_addr / r_data        : packed read addresses / read data, slice p = port p
//   busy                   : clear sequence running (reads return 0)
//   wr_drop                : one-cycle pulse, a write arrived during a clear
module multiport_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [DATA_W/8-1:0]      w_be,
    input  logic                     clr_req,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    output logic [NUM_RD*DATA_W-1:0] r_data,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    // Storage has no reset; the clear sequencer initialises it.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_drop;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_zero_hit;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_merged;

    reg_file_clear_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk      (clk),
        .arst_n   (arst_n),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_zero_hit = (ZERO_REG != 0) && (w_addr == '0);
    // A write is accepted only outside the clear and not to a hardwired zero.
    assign w_wr_ok    = we && !w_busy && !w_zero_hit;
    assign w_merged   = DATA_W'(be_merge(MAX_DW'(r_mem[w_addr]),
                                         MAX_DW'(w_data),
                                         (MAX_DW/8)'(w_be)));

    always_ff @(posedge clk) begin
        if (w_clr_we)     r_mem[w_clr_addr] <= '0;
        else if (w_wr_ok) r_mem[w_addr]     <= w_merged;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_wr_drop <= 1'b0;
        else         r_wr_drop <= we && w_busy;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = r_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            if (w_busy)
                w_rd = '0;
            else if ((ZERO_REG != 0) && (w_ra == '0))
                w_rd = '0;
            else if ((BYPASS != 0) && w_wr_ok && (w_ra == w_addr))
                w_rd = w_merged;
        end

        assign r_data[p*DATA_W +: DATA_W] = w_rd;
    end

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;

    localparam int DEPTH = 8;

    // DUT 0: defaults (8-bit, no zero reg, bypass). DUT 1: 16-bit, zero reg, no bypass.
    logic        clk, arst_n;
    logic        we_i  [2];
    logic [2:0]  wa_i  [2];
    logic [15:0] wd_i  [2];
    logic [1:0]  be_i  [2];
    logic        clr_i [2];
    logic [5:0]  ra_i  [2];
    logic [15:0] rd0;
    logic [31:0] rd1;
    logic        busy0, busy1, drop0, drop1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining clear cycles, pending drop pulse, entry contents.
    int          clr_rem [2];
    logic        drop_m  [2];
    logic [15:0] mem_m   [2][DEPTH];

    multiport_reg_file u_dut0 (
        .clk(clk), .arst_n(arst_n), .we(we_i[0]), .w_addr(wa_i[0]),
        .w_data(wd_i[0][7:0]), .w_be(be_i[0][0:0]), .clr_req(clr_i[0]),
        .r_addr(ra_i[0]), .r_data(rd0), .busy(busy0), .wr_drop(drop0)
    );

    multiport_reg_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .we(we_i[1]), .w_addr(wa_i[1]),
        .w_data(wd_i[1]), .w_be(be_i[1]), .clr_req(clr_i[1]),
        .r_addr(ra_i[1]), .r_data(rd1), .busy(busy1), .wr_drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mrg(input int d, input logic [15:0] old_v,
                                        input logic [15:0] nv, input logic [1:0] be);
        logic [15:0] r;
        r = old_v;
        if (be[0]) r[7:0] = nv[7:0];
        if (d == 1 && be[1]) r[15:8] = nv[15:8];
        return (d == 0) ? (r & 16'h00FF) : r;
    endfunction

    function automatic logic [15:0] model_rd(input int d, input int p);
        logic [2:0] a;
        logic       zr, wok;
        a   = ra_i[d][p*3 +: 3];
        zr  = (d == 1);
        wok = we_i[d] && !(zr && wa_i[d] == 3'd0);
        if (clr_rem[d] > 0) return 16'h0;
        if (zr && a == 3'd0) return 16'h0;
        if (d == 0 && wok && a == wa_i[d]) return mrg(d, mem_m[d][a], wd_i[d], be_i[d]);
        return mem_m[d][a];
    endfunction

    function automatic logic [15:0] dut_rd(input int d, input int p);
        return (d == 0) ? {8'h0, rd0[p*8 +: 8]} : rd1[p*16 +: 16];
    endfunction

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++)
                chk($sformatf("%s rd d%0d p%0d", tag, d, p), 32'(dut_rd(d, p)), 32'(model_rd(d, p)));
            chk($sformatf("%s busy d%0d", tag, d), 32'(d == 0 ? busy0 : busy1), 32'(clr_rem[d] > 0));
            chk($sformatf("%s drop d%0d", tag, d), 32'(d == 0 ? drop0 : drop1), 32'(drop_m[d]));
        end
    endtask

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!arst_n) begin
                clr_rem[d] = DEPTH;
                drop_m[d]  = 1'b0;
            end else if (clr_rem[d] > 0) begin
                drop_m[d] = we_i[d];
                mem_m[d][DEPTH - clr_rem[d]] = 16'h0;
                clr_rem[d]--;
            end else begin
                drop_m[d] = 1'b0;
                if (we_i[d] && !(d == 1 && wa_i[d] == 3'd0))
                    mem_m[d][wa_i[d]] = mrg(d, mem_m[d][wa_i[d]], wd_i[d], be_i[d]);
                if (clr_i[d]) clr_rem[d] = DEPTH;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            we_i[d] = 0; wa_i[d] = 0; wd_i[d] = 0; be_i[d] = 0; clr_i[d] = 0; ra_i[d] = 0;
        end
    endtask

    task automatic assert_rst();
        arst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clr_rem[d] = DEPTH;
            drop_m[d]  = 1'b0;
        end
    endtask

    // Count cycles until DUT d leaves busy, bounded.
    task automatic count_busy(input int d, output int n);
        n = 0;
        while ((d == 0 ? busy0 : busy1) && n < 40) begin
            check_all("clr");
            step();
            n++;
        end
    endtask

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       be;
        logic [2:0] ra0, ra1;
        logic [7:0] e0, e1;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        tbl[0] = '{1, 3'd3, 8'hA5, 1, 3'd3, 3'd3, 8'hA5, 8'hA5}; // bypass on write
        tbl[1] = '{0, 3'd0, 8'h00, 0, 3'd3, 3'd3, 8'hA5, 8'hA5}; // both ports same entry
        tbl[2] = '{1, 3'd5, 8'h3C, 1, 3'd5, 3'd3, 8'h3C, 8'hA5}; // bypass port 0 only
        tbl[3] = '{1, 3'd5, 8'hFF, 0, 3'd5, 3'd5, 8'h3C, 8'h3C}; // zero byte enable
        tbl[4] = '{0, 3'd0, 8'h00, 0, 3'd5, 3'd0, 8'h3C, 8'h00};
        tbl[5] = '{1, 3'd0, 8'h11, 1, 3'd0, 3'd7, 8'h11, 8'h00}; // entry 0 writable
        tbl[6] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 8'h11, 8'h3C};

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < DEPTH; a++) mem_m[d][a] = 16'h0;
        idle_inputs();
        assert_rst();
        #1;
        check_all("in_reset");
        chk("reset busy", 32'(busy0), 32'd1);
        repeat (3) step();
        arst_n = 1'b1;
        count_busy(0, n);
        chk("reset clear length", 32'(n), 32'd8);
        check_all("post_reset");

        // Table-driven directed vectors on DUT 0.
        for (int i = 0; i < 7; i++) begin
            we_i[0] = tbl[i].we; wa_i[0] = tbl[i].wa; wd_i[0] = {8'h0, tbl[i].wd};
            be_i[0] = {1'b0, tbl[i].be}; ra_i[0] = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("tbl[%0d] p0", i), 32'(rd0[7:0]), 32'(tbl[i].e0));
            chk($sformatf("tbl[%0d] p1", i), 32'(rd0[15:8]), 32'(tbl[i].e1));
            check_all("tbl");
            step();
        end
        idle_inputs();

        // DUT 1: 16-bit byte merge, no bypass, hardwired zero entry.
        we_i[1] = 1; wa_i[1] = 3'd2; wd_i[1] = 16'h1234; be_i[1] = 2'b11; ra_i[1] = {3'd2, 3'd2};
        #1; chk("nobyp first write", 32'(rd1[15:0]), 32'h0); check_all("d1");
        step();
        wd_i[1] = 16'hABCD; be_i[1] = 2'b10;
        #1; chk("nobyp old value", 32'(rd1[15:0]), 32'h1234); check_all("d1");
        step();
        we_i[1] = 0;
        #1; chk("byte merge", 32'(rd1[15:0]), 32'hAB34); chk("merge p1", 32'(rd1[31:16]), 32'hAB34);
        we_i[1] = 1; wa_i[1] = 3'd0; wd_i[1] = 16'hFFFF; be_i[1] = 2'b11; ra_i[1] = {3'd2, 3'd0};
        #1; check_all("zr");
        step();
        we_i[1] = 0;
        #1; chk("zero reg read", 32'(rd1[15:0]), 32'h0); chk("zero reg drop", 32'(drop1), 32'd0);

        // Write during a clear is dropped and leaves the entry zero.
        idle_inputs();
        clr_i[0] = 1; #1; check_all("clr_req"); step();
        clr_i[0] = 0; we_i[0] = 1; wa_i[0] = 3'd3; wd_i[0] = 16'h77; be_i[0] = 2'b01;
        #1; check_all("drop"); step();
        we_i[0] = 0;
        #1; chk("wr_drop pulse", 32'(drop0), 32'd1); check_all("drop");
        count_busy(0, n);
        chk("clear timeout", 32'(busy0), 32'd0);
        ra_i[0] = {3'd3, 3'd3};
        #1; chk("dropped entry", 32'(rd0[7:0]), 32'h0); chk("wr_drop low", 32'(drop0), 32'd0);

        // Same-cycle write and clear: write lands, then clear zeroes it.
        we_i[0] = 1; wa_i[0] = 3'd6; wd_i[0] = 16'h42; be_i[0] = 2'b01; clr_i[0] = 1; ra_i[0] = {3'd6, 3'd6};
        #1; chk("wr+clr bypass", 32'(rd0[7:0]), 32'h42); step();
        idle_inputs(); ra_i[0] = {3'd6, 3'd6};
        #1; chk("wr+clr busy", 32'(busy0), 32'd1);
        count_busy(0, n);
        chk("wr+clr length", 32'(n), 32'd8);
        #1; chk("wr+clr entry", 32'(rd0[7:0]), 32'h0);

        // Randomized traffic on both DUTs against the model.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                we_i[d]  = 1'($urandom);
                wa_i[d]  = 3'($urandom);
                wd_i[d]  = 16'($urandom);
                be_i[d]  = 2'($urandom);
                clr_i[d] = ($urandom_range(0, 31) == 0);
                ra_i[d]  = 6'($urandom);
            end
            #1; check_all("rand");
            step();
        end
        idle_inputs();

        // Reset mid-clear restarts a full clear.
        clr_i[0] = 1; clr_i[1] = 1; step();
        idle_inputs(); repeat (3) step();
        assert_rst();
        #1; check_all("midclr_rst"); chk("midclr busy", 32'(busy1), 32'd1);
        step(); step();
        arst_n = 1'b1;
        count_busy(1, n);
        chk("midclr length", 32'(n), 32'd8);
        check_all("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter DATA_W, default 8: entry width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, 1..8.
REQ-004 Parameter ZERO_REG, default 0: when 1, entry 0 always reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 arst_n  in  1  reset; asynchronous and active-low.
REQ-008 we  in  1  write request, sampled at the rising edge of clk.
REQ-009 w_addr  in  ADDR_W  write address.
REQ-010 w_data  in  DATA_W  write data.
REQ-011 w_be  in  DATA_W/8  byte enables; bit k selects w_data[8k+7:8k].
REQ-012 clr_req  in  1  request to zero every entry.
REQ-013 r_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses slice p.
REQ-014 r_data  out  NUM_RD*DATA_W  packed read data; port p drives slice p.
REQ-015 busy  out  1  high while the clear sequence runs.
REQ-016 wr_drop  out  1  registered one-cycle pulse: a write was discarded.

Function
REQ-017 Two states, CLEAR and IDLE; a clear counter of ADDR_W bits indexes the entry being zeroed.
REQ-018 CLEAR: each cycle, write 0 to entry[counter] and increment counter; on the cycle counter = DEPTH-1, go to IDLE. A clear therefore takes exactly DEPTH cycles.
REQ-019 IDLE: clr_req=1 goes to CLEAR on the next cycle with counter=0. clr_req in CLEAR is ignored and does not restart the sequence.
REQ-020 busy SHALL be 1 exactly while in CLEAR.
REQ-021 IDLE write: if we=1, each byte k with w_be[k]=1 of entry[w_addr] takes w_data byte k. Other bytes keep their value.
REQ-022 IDLE write with w_be all-zero: no change, and no wr_drop.
REQ-023 we=1 while in CLEAR: the write is discarded and wr_drop=1 on the following cycle. Otherwise wr_drop=0.
REQ-024 ZERO_REG=1 and w_addr=0: the write is ignored silently, with no wr_drop.
REQ-025 Reads are combinational; r_data[p] = entry[r_addr[p]] with zero latency.
REQ-026 While busy=1, every r_data port SHALL read 0.
REQ-027 ZERO_REG=1 and r_addr[p]=0: r_data[p] = 0 always.
REQ-028 BYPASS=1, IDLE, we=1 and r_addr[p]=w_addr (not suppressed by REQ-024): r_data[p] returns the post-write merged value in the same cycle.
REQ-029 BYPASS=0: the same case returns the pre-write stored value.
REQ-030 Multiple read ports may address the same entry; each returns the identical value.
REQ-031 clr_req=1 and we=1 in the same IDLE cycle: the write completes, then the clear starts the next cycle and zeroes that entry as well.

Reset
REQ-032 While arst_n=0: state=CLEAR, counter=0, busy=1, wr_drop=0, all r_data=0.
REQ-033 After arst_n deasserts, the block SHALL run a full DEPTH-cycle clear before reaching IDLE.
REQ-034 Storage SHALL NOT be asynchronously reset; the sequencer initialises it.
REQ-035 arst_n asserted mid-clear or mid-write aborts the operation; the sequence restarts from counter=0.

Structure
REQ-036 Package reg_file_pkg SHALL hold the state enum (CLEAR, IDLE) and the byte-merge function (old, new, be) -> merged.
REQ-037 The FSM and counter SHALL be one sub-module, reg_file_clear_seq (ports: clk, arst_n, clr_req, busy, clr_we, clr_addr).
REQ-038 Storage, write merge, bypass and read muxing SHALL stay in multiport_reg_file.

Verification
REQ-039 Release reset, defaults -> busy=1 for exactly 8 cycles, then 0; all r_data=0 throughout.
REQ-040 Write 0xA5 at address 3 with w_be=1, then read address 3 on both ports -> both ports show 0xA5 the next cycle.
REQ-041 BYPASS=1: write 0x3C at address 5 while r_addr[0]=5 -> r_data[0]=0x3C in the same cycle. With BYPASS=0 -> the old value.
REQ-042 DATA_W=16: entry=0x1234, write 0xABCD with w_be=2'b10 -> entry reads 0xAB34.
REQ-043 Pulse clr_req, then assert we during the clear -> wr_drop=1 one cycle later; entry unchanged (0) after the clear.
REQ-044 ZERO_REG=1: write 0xFF to address 0 -> reads 0, wr_drop=0. Assert arst_n low mid-clear -> the clear restarts and lasts a full 8 cycles.
